// File: rtl/fifo_rd_streamer.sv
// fifo_rd_streamer: turns a registered-output FIFO read port into a
// valid/ready stream. Words return one cycle after each read strobe and land
// in a 2-entry in-order skid buffer, so reads can be issued ahead of
// downstream acceptance without ever overflowing.
// Optional feature: define FIFO_RD_STREAMER_CNT_EN to enable the xfer_cnt
// accepted-word counter; when undefined xfer_cnt is tied to zero.
module fifo_rd_streamer #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  rd_clk,
  input  logic                  rst_n,
  input  logic                  stream_en,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [CNT_WIDTH-1:0]  xfer_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

  occ_e                  state_q;
  logic                  inflight_q;
  logic                  valid_q;
  logic [DATA_WIDTH-1:0] head_q;   // oldest buffered word, drives m_data
  logic [DATA_WIDTH-1:0] tail_q;   // second word when two are buffered
  logic [1:0]            occ;
  logic                  pop;
  logic [2:0]            level_d;  // occupancy after this cycle's capture and pop

  assign occ     = state_q;
  assign pop     = valid_q & m_ready;
  // pop implies occ >= 1, so the subtraction never wraps
  assign level_d = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};

  // Only read when the word it returns is guaranteed a free buffer slot;
  // rst_n gating keeps the strobe low for the whole reset interval.
  assign fifo_rd_en = rst_n & stream_en & ~fifo_empty & (level_d <= 3'd1);

  assign m_valid = valid_q;
  assign m_data  = head_q;

  // Occupancy FSM: captures returning words behind the remaining entry and shifts on pop
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      inflight_q <= 1'b0;
      valid_q    <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      inflight_q <= fifo_rd_en;
      case (state_q)
        EMPTY: begin
          if (inflight_q) begin
            head_q  <= fifo_data;
            state_q <= ONE;
            valid_q <= 1'b1;
          end
        end
        ONE: begin
          case ({inflight_q, pop})
            2'b11: head_q <= fifo_data;
            2'b10: begin
              tail_q  <= fifo_data;
              state_q <= TWO;
            end
            2'b01: begin
              state_q <= EMPTY;
              valid_q <= 1'b0;
            end
            default: ;
          endcase
        end
        TWO: begin
          // a capture without a pop cannot happen here: the read gate forbids it
          if (pop) begin
            head_q <= tail_q;
            if (inflight_q) begin
              tail_q <= fifo_data;
            end else begin
              state_q <= ONE;
            end
          end
        end
        default: begin
          state_q <= EMPTY;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef FIFO_RD_STREAMER_CNT_EN
  logic [CNT_WIDTH-1:0] cnt_q;

  // Accepted-word counter, wraps naturally at 2^CNT_WIDTH
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (pop) begin
      cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

  assign xfer_cnt = cnt_q;
`else
  assign xfer_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// Testbench for fifo_rd_streamer: directed table and corner-case sequences
// plus a randomized run scored against a word-count level reference model.
module tb_fifo_rd_streamer;

  localparam int DW    = 32;
  localparam int CW    = 4;
  localparam int MEMSZ = 16384;

  logic          rd_clk;
  logic          rst_n;
  logic          stream_en;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic [CW-1:0] xfer_cnt;

  fifo_rd_streamer #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .rd_clk     (rd_clk),
    .rst_n      (rst_n),
    .stream_en  (stream_en),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_data  (fifo_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .xfer_cnt   (xfer_cnt)
  );

  initial rd_clk = 1'b0;
  always #5 rd_clk = ~rd_clk;

  // ---------------- source FIFO model ----------------
  logic [DW-1:0] mem [MEMSZ];
  int            wr_ptr = 0;
  int            rd_ptr = 0;
  logic          flush = 1'b0;
  logic          force_empty = 1'b0;

  assign fifo_empty = force_empty | (rd_ptr == wr_ptr);

  initial begin
    fifo_data = '0;
    forever begin
      @(posedge rd_clk);
      if (flush) rd_ptr <= wr_ptr;
      else if (fifo_rd_en) begin
        fifo_data <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + 1;
      end
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic int exp_cnt(input int pops);
`ifdef FIFO_RD_STREAMER_CNT_EN
    return pops % (1 << CW);
`else
    return 0 * pops;
`endif
  endfunction

  // Reference model: the DUT holds (issued - popped) words in flight or
  // buffered; the word read last cycle is still in flight.
  logic [DW-1:0] exp_q[$];
  int            issued = 0;
  int            popped = 0;
  int            last_rd = 0;
  bit            prev_stall = 0;
  logic [DW-1:0] prev_data = '0;

  initial begin
    forever begin
      @(negedge rd_clk);
      if (rst_n !== 1'b1) begin
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_xfer_cnt", xfer_cnt, 0);
        check("rst_fifo_rd_en", fifo_rd_en, 0);
        issued = 0; popped = 0; last_rd = 0; prev_stall = 0;
        exp_q.delete();
      end else begin
        int  outstanding;
        bit  e_valid, e_pop, e_rd;
        outstanding = issued - popped;
        e_valid = (outstanding - last_rd) > 0;
        e_pop   = e_valid & m_ready;
        e_rd    = stream_en & ~fifo_empty & ((outstanding - int'(e_pop)) <= 1);
        check("m_valid", m_valid, e_valid);
        check("fifo_rd_en", fifo_rd_en, e_rd);
        check("xfer_cnt", xfer_cnt, exp_cnt(popped));
        if (prev_stall) check("hold_m_data", m_data, prev_data);
        if (e_pop) begin
          if (exp_q.size() == 0) check("scoreboard_underrun", 0, 1);
          else check("m_data", m_data, exp_q.pop_front());
        end
        if (fifo_rd_en === 1'b1) exp_q.push_back(mem[rd_ptr]);
        issued  += (fifo_rd_en === 1'b1) ? 1 : 0;
        popped  += int'(e_pop);
        last_rd  = (fifo_rd_en === 1'b1) ? 1 : 0;
        prev_stall = (m_valid === 1'b1) && (m_ready === 1'b0);
        prev_data  = m_data;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus helpers ----------------
  logic [DW-1:0] got_q[$];

  task automatic tick();
    @(posedge rd_clk);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    if (wr_ptr < MEMSZ) begin
      mem[wr_ptr] = w;
      wr_ptr++;
    end
  endtask

  task automatic do_reset();
    stream_en = 1'b0; m_ready = 1'b0; force_empty = 1'b0;
    rst_n = 1'b0; flush = 1'b1;
    tick(); tick();
    flush = 1'b0; rst_n = 1'b1;
  endtask

  task automatic collect(input int n, input int budget, input bit toggle);
    got_q.delete();
    for (int c = 0; c < budget && got_q.size() < n; c++) begin
      @(negedge rd_clk);
      if (m_valid === 1'b1 && m_ready === 1'b1) got_q.push_back(m_data);
      tick();
      if (toggle) m_ready = ~m_ready;
    end
    check("collect_count", got_q.size(), n);
  endtask

  typedef struct {
    logic          se;
    logic          mr;
    logic          exp_rd;
    logic          exp_valid;
    logic [DW-1:0] exp_data;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int  reads, pops;
    bit  seen;
    logic [DW-1:0] last_word;

    rst_n = 1'b1; stream_en = 1'b0; m_ready = 1'b0;
    #1 rst_n = 1'b0;

    // 1: three words, full-rate stream, 2-cycle first-word latency
    tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'hA1};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'hA2};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'hA3};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
    do_reset();
    push_word(32'hA1); push_word(32'hA2); push_word(32'hA3);
    for (int i = 0; i < 6; i++) begin
      stream_en = tbl[i].se;
      m_ready   = tbl[i].mr;
      @(negedge rd_clk);
      check($sformatf("tbl%0d_rd_en", i), fifo_rd_en, tbl[i].exp_rd);
      check($sformatf("tbl%0d_valid", i), m_valid, tbl[i].exp_valid);
      if (tbl[i].exp_valid) check($sformatf("tbl%0d_data", i), m_data, tbl[i].exp_data);
      $display("tbl %0d: rd_en=%0b valid=%0b data=%0h", i, fifo_rd_en, m_valid, m_data);
      tick();
    end

    // 2: stalled sink, exactly two reads, head held, then in-order drain
    do_reset();
    for (int i = 0; i < 5; i++) push_word(32'hB0 + i);
    stream_en = 1'b1;
    reads = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge rd_clk);
      reads += (fifo_rd_en === 1'b1) ? 1 : 0;
      tick();
    end
    check("stall_read_pulses", reads, 2);
    check("stall_valid", m_valid, 1);
    check("stall_head", m_data, 32'hB0);
    m_ready = 1'b1;
    collect(5, 20, 1'b0);
    for (int i = 0; i < got_q.size(); i++) check($sformatf("stall_word%0d", i), got_q[i], 32'hB0 + i);
    $display("stall scenario: %0d reads while stalled, %0d words drained", reads, got_q.size());

    // 3: m_ready toggling with a continuous source
    do_reset();
    for (int i = 0; i < 16; i++) push_word(32'hC0 + i);
    stream_en = 1'b1; m_ready = 1'b1;
    collect(16, 100, 1'b1);
    for (int i = 0; i < got_q.size(); i++) check($sformatf("toggle_word%0d", i), got_q[i], 32'hC0 + i);
    $display("toggle scenario: %0d words received", got_q.size());

    // 4: fifo_empty rises mid-burst
    do_reset();
    for (int i = 0; i < 8; i++) push_word(32'hD0 + i);
    stream_en = 1'b1; m_ready = 1'b1;
    reads = 0; pops = 0; last_word = '0;
    for (int c = 0; c < 12; c++) begin
      if (c == 3) force_empty = 1'b1;
      @(negedge rd_clk);
      if (c == 3) check("empty_blocks_rd", fifo_rd_en, 0);
      reads += (fifo_rd_en === 1'b1) ? 1 : 0;
      if (m_valid === 1'b1 && m_ready === 1'b1) begin
        pops++;
        last_word = m_data;
      end
      tick();
    end
    check("empty_reads", reads, 3);
    check("empty_pops", pops, 3);
    check("empty_last_word", last_word, 32'hD2);
    $display("empty scenario: reads=%0d pops=%0d last=%0h", reads, pops, last_word);

    // 5: reset mid-transfer with a full buffer
    do_reset();
    for (int i = 0; i < 6; i++) push_word(32'hE0 + i);
    stream_en = 1'b1; m_ready = 1'b1;
    repeat (4) tick();
    m_ready = 1'b0;
    repeat (4) tick();
    check("pre_reset_valid", m_valid, 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", m_valid, 0);
    check("async_rst_data", m_data, 0);
    check("async_rst_cnt", xfer_cnt, 0);
    check("async_rst_rd_en", fifo_rd_en, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    push_word(32'h55);
    rst_n = 1'b1; m_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge rd_clk);
      if (m_valid === 1'b1) begin
        seen = 1;
        check("first_after_reset", m_data, 32'h55);
      end
      tick();
    end
    check("seen_after_reset", seen, 1);
    $display("reset scenario: fresh word seen=%0b", seen);

    // 6: 17 pops through a 4-bit counter
    do_reset();
    for (int i = 0; i < 17; i++) push_word(32'hF00 + i);
    stream_en = 1'b1; m_ready = 1'b1;
    collect(17, 60, 1'b0);
    check("cnt_after_17", xfer_cnt, exp_cnt(17));
    $display("counter scenario: xfer_cnt=%0d", xfer_cnt);

    // randomized run against the reference model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      stream_en   = ($urandom_range(0, 9) < 8);
      m_ready     = ($urandom_range(0, 9) < 7);
      force_empty = ($urandom_range(0, 19) == 0);
      if (wr_ptr - rd_ptr < 6) begin
        int n;
        n = $urandom_range(0, 2);
        for (int k = 0; k < n; k++) push_word($urandom);
      end
      tick();
    end
    stream_en = 1'b0; force_empty = 1'b0; m_ready = 1'b1;
    repeat (8) tick();
    @(negedge rd_clk);
    check("random_drain_valid", m_valid, 0);
    check("random_drain_scoreboard", exp_q.size(), 0);
    $display("random run: %0d words read, %0d accepted", issued, popped);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
